button_event_arbiter: RTL and testbench

Collects single-cycle press pulses from up to N_BTN button shaper instances and latches each one as a pending event. It grants pending events one at a time, in round-robin order, to a single downstream consumer such as the LCD command sequencer, using a valid/ready handshake. After each accepted event it enforces a programmable hold-off gap, so the consumer never sees back-to-back button events.

---
 rtl/button_event_arbiter.sv | 175 +++++++++++++++++
 tb/tb_button_event_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_arbiter.sv
// -----------------------------------------------------------------------------
// button_event_arbiter
//
// Latches single-cycle press pulses from N_BTN button shapers as pending
// events and hands them out one at a time, round-robin, to a single consumer
// over a valid/ready handshake. After every accepted event a hold-off gap of
// HOLDOFF idle cycles is inserted so the consumer never sees back-to-back
// button events. A press that arrives while the same button is still pending
// is lost and recorded in a sticky per-button overrun flag.
//
// Ports:
//   clk          system clock, everything is on the rising edge
//   rst          synchronous, active-high reset
//   btn_pulse    one-cycle press pulses, one bit per button
//   evt_ready    consumer accepts the presented event this cycle
//   clr_overrun  one-cycle pulse clearing all overrun flags
//   evt_valid    an event is presented on evt_id
//   evt_id       index of the presented button
//   overrun      sticky per-button "a press was lost" flags
//   busy         high while granting or holding off
// -----------------------------------------------------------------------------
module button_event_arbiter #(
  parameter int N_BTN   = 4,
  parameter int ID_W    = 2,
  parameter int HOLDOFF = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_pulse,
  input  logic             evt_ready,
  input  logic             clr_overrun,
  output logic             evt_valid,
  output logic [ID_W-1:0]  evt_id,
  output logic [N_BTN-1:0] overrun,
  output logic             busy
);

  // Index width that exactly addresses the pending vector.
  localparam int IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  // Hold-off counter must be able to hold the value HOLDOFF itself.
  localparam int CNT_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic [N_BTN-1:0] pending_r;
  logic [N_BTN-1:0] pending_nx_s;
  logic [N_BTN-1:0] clear_s;
  logic [N_BTN-1:0] lost_s;
  logic [N_BTN-1:0] overrun_nx_s;
  logic [ID_W-1:0]  last_grant_r;
  logic [ID_W-1:0]  last_grant_nx_s;
  logic [ID_W-1:0]  evt_id_nx_s;
  logic [ID_W-1:0]  sel_id_s;
  logic             sel_found_s;
  logic             take_s;
  logic [CNT_W-1:0] hold_cnt_r;
  logic [CNT_W-1:0] hold_cnt_nx_s;
  logic [IDX_W-1:0] cand_s;

  // Pending latch and overrun bookkeeping.
  always_comb begin
    take_s  = (state_r == ST_GRANT) && evt_ready;
    clear_s = {N_BTN{1'b0}};
    if (take_s) begin
      // One-hot of the button whose event is being accepted right now.
      clear_s = {{(N_BTN-1){1'b0}}, 1'b1} << evt_id;
    end else begin
      clear_s = {N_BTN{1'b0}};
    end
    // A pulse coinciding with its own clear simply re-arms the bit.
    pending_nx_s = btn_pulse | (pending_r & ~clear_s);
    lost_s       = btn_pulse & pending_r & ~clear_s;
    // A new loss in the same cycle as clr_overrun must survive the clear.
    if (clr_overrun) begin
      overrun_nx_s = lost_s;
    end else begin
      overrun_nx_s = overrun | lost_s;
    end
  end

  // Round-robin pick: first pending bit searching upward from last_grant+1.
  always_comb begin
    sel_found_s = 1'b0;
    sel_id_s    = {ID_W{1'b0}};
    cand_s      = {IDX_W{1'b0}};
    for (int k = 1; k <= N_BTN; k++) begin
      cand_s = IDX_W'((int'(last_grant_r) + k) % N_BTN);
      if (!sel_found_s && pending_r[cand_s]) begin
        sel_found_s = 1'b1;
        sel_id_s    = ID_W'(cand_s);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Next-state logic for the IDLE / GRANT / HOLD controller.
  always_comb begin
    state_nx_s      = state_r;
    evt_id_nx_s     = evt_id;
    last_grant_nx_s = last_grant_r;
    hold_cnt_nx_s   = hold_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (sel_found_s) begin
          state_nx_s  = ST_GRANT;
          evt_id_nx_s = sel_id_s;
        end else begin
          state_nx_s  = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (evt_ready) begin
          last_grant_nx_s = evt_id;
          if (HOLDOFF == 0) begin
            state_nx_s    = ST_IDLE;
            hold_cnt_nx_s = {CNT_W{1'b0}};
          end else begin
            state_nx_s    = ST_HOLD;
            hold_cnt_nx_s = CNT_W'(HOLDOFF);
          end
        end else begin
          // evt_id is left untouched so it stays stable until accepted.
          state_nx_s = ST_GRANT;
        end
      end
      ST_HOLD: begin
        // Leaving on the count of 1 yields exactly HOLDOFF cycles in HOLD.
        if (hold_cnt_r <= CNT_W'(1)) begin
          state_nx_s    = ST_IDLE;
          hold_cnt_nx_s = {CNT_W{1'b0}};
        end else begin
          state_nx_s    = ST_HOLD;
          hold_cnt_nx_s = hold_cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_nx_s    = ST_IDLE;
        hold_cnt_nx_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, pending/overrun flags and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      pending_r    <= {N_BTN{1'b0}};
      overrun      <= {N_BTN{1'b0}};
      evt_id       <= {ID_W{1'b0}};
      // Button 0 gets first priority out of reset.
      last_grant_r <= ID_W'(N_BTN - 1);
      hold_cnt_r   <= {CNT_W{1'b0}};
      evt_valid    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      pending_r    <= pending_nx_s;
      overrun      <= overrun_nx_s;
      evt_id       <= evt_id_nx_s;
      last_grant_r <= last_grant_nx_s;
      hold_cnt_r   <= hold_cnt_nx_s;
      // Outputs are decoded from the next state so they line up with it.
      evt_valid    <= (state_nx_s == ST_GRANT);
      busy         <= (state_nx_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for button_event_arbiter (N_BTN=4, ID_W=2, HOLDOFF=16).
// Cycle-accurate directed vectors: each record drives the inputs for n cycles
// and states the outputs expected during each of those cycles. Inputs are
// driven and outputs sampled 1 time unit after the rising edge. A hand-written
// round-robin sequence follows, with bounded waits.
// -----------------------------------------------------------------------------
module tb_button_event_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] btn_pulse;
  logic       evt_ready;
  logic       clr_overrun;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic [3:0] overrun;
  logic       busy;

  int checks;
  int failures;

  typedef struct {
    int         n;
    logic       rst;
    logic [3:0] pulse;
    logic       rdy;
    logic       clr;
    logic       exp_valid;
    logic       chk_id;
    logic [1:0] exp_id;
    logic [3:0] exp_ovr;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];

  button_event_arbiter #(
    .N_BTN  (4),
    .ID_W   (2),
    .HOLDOFF(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_pulse  (btn_pulse),
    .evt_ready  (evt_ready),
    .clr_overrun(clr_overrun),
    .evt_valid  (evt_valid),
    .evt_id     (evt_id),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d t=%0t actual=%0h required=%0h", name, idx, $time, act, exp);
    end
  endtask

  task automatic add(input int n, input logic r, input logic [3:0] p, input logic rdy,
                     input logic c, input logic ev, input logic ci, input logic [1:0] id,
                     input logic [3:0] ov, input logic eb);
    vec_t t;
    t.n = n; t.rst = r; t.pulse = p; t.rdy = rdy; t.clr = c;
    t.exp_valid = ev; t.chk_id = ci; t.exp_id = id; t.exp_ovr = ov; t.exp_busy = eb;
    vecs.push_back(t);
  endtask

  initial begin
    int cnt;
    int g;
    checks   = 0;
    failures = 0;

    // n, rst, pulse, rdy, clr | valid, chk_id, id, overrun, busy
    // Reset with all buttons pressed: outputs zero, nothing latched.
    add(2,  1'b1, 4'b1111, 1'b0, 1'b0,  1'b0, 1'b1, 2'd0, 4'b0000, 1'b0);
    add(4,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    // Single press on button 2: valid two cycles later, 16 hold cycles.
    add(1,  1'b0, 4'b0100, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b1, 1'b1, 2'd2, 4'b0000, 1'b1);
    add(16, 1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    // Reset, then buttons 0,1,3 together: grants 0,1,3.
    add(1,  1'b1, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1,  1'b0, 4'b1011, 1'b1, 1'b0,  1'b0, 1'b1, 2'd0, 4'b0000, 1'b0);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b1, 1'b1, 2'd0, 4'b0000, 1'b1);
    add(16, 1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b1, 1'b1, 2'd1, 4'b0000, 1'b1);
    add(16, 1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b1, 1'b1, 2'd3, 4'b0000, 1'b1);
    add(16, 1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    // Buttons 0,1 together after last grant 3: order must be 0 then 1.
    add(1,  1'b0, 4'b0011, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b1, 1'b1, 2'd0, 4'b0000, 1'b1);
    add(16, 1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b1, 1'b1, 2'd1, 4'b0000, 1'b1);
    add(16, 1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    // Button 1 stalled in GRANT, re-pressed: overrun, clr+set same cycle keeps it.
    add(1,  1'b0, 4'b0010, 1'b0, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1,  1'b0, 4'b0000, 1'b0, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(3,  1'b0, 4'b0000, 1'b0, 1'b0,  1'b1, 1'b1, 2'd1, 4'b0000, 1'b1);
    add(1,  1'b0, 4'b0010, 1'b0, 1'b0,  1'b1, 1'b1, 2'd1, 4'b0000, 1'b1);
    add(3,  1'b0, 4'b0000, 1'b0, 1'b0,  1'b1, 1'b1, 2'd1, 4'b0010, 1'b1);
    add(1,  1'b0, 4'b0010, 1'b0, 1'b1,  1'b1, 1'b1, 2'd1, 4'b0010, 1'b1);
    add(2,  1'b0, 4'b0000, 1'b0, 1'b0,  1'b1, 1'b1, 2'd1, 4'b0010, 1'b1);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b1, 1'b1, 2'd1, 4'b0010, 1'b1);
    add(16, 1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0010, 1'b1);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b1,  1'b0, 1'b0, 2'd0, 4'b0010, 1'b0);
    add(3,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    // Button 2 re-pressed in its accept cycle: no overrun, second event.
    add(1,  1'b0, 4'b0100, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1,  1'b0, 4'b0100, 1'b1, 1'b0,  1'b1, 1'b1, 2'd2, 4'b0000, 1'b1);
    add(16, 1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b1, 1'b1, 2'd2, 4'b0000, 1'b1);
    add(5,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);
    // Reset during HOLD, then press 3: grant id 3 two cycles after the press.
    add(1,  1'b1, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);
    add(1,  1'b0, 4'b1000, 1'b1, 1'b0,  1'b0, 1'b1, 2'd0, 4'b0000, 1'b0);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b1, 1'b1, 2'd3, 4'b0000, 1'b1);
    add(16, 1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    // Grant 2, reset in HOLD, press 0 and 3: priority restarts at 0.
    add(1,  1'b0, 4'b0100, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b1, 1'b1, 2'd2, 4'b0000, 1'b1);
    add(3,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);
    add(1,  1'b1, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);
    add(1,  1'b0, 4'b1001, 1'b1, 1'b0,  1'b0, 1'b1, 2'd0, 4'b0000, 1'b0);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b1, 1'b1, 2'd0, 4'b0000, 1'b1);
    add(16, 1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b1, 1'b1, 2'd3, 4'b0000, 1'b1);
    add(16, 1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);
    add(1,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    // Reset mid-handshake drops valid and discards the in-flight event.
    add(1,  1'b0, 4'b0001, 1'b0, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1,  1'b0, 4'b0000, 1'b0, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1,  1'b0, 4'b0000, 1'b0, 1'b0,  1'b1, 1'b1, 2'd0, 4'b0000, 1'b1);
    add(1,  1'b1, 4'b0000, 1'b0, 1'b0,  1'b1, 1'b1, 2'd0, 4'b0000, 1'b1);
    add(1,  1'b0, 4'b0000, 1'b0, 1'b0,  1'b0, 1'b1, 2'd0, 4'b0000, 1'b0);
    add(2,  1'b0, 4'b0000, 1'b1, 1'b0,  1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);

    // First cycle: reset asserted, outputs not yet defined.
    rst         = 1'b1;
    btn_pulse   = 4'b1111;
    evt_ready   = 1'b0;
    clr_overrun = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < vecs.size(); v++) begin
      for (int c = 0; c < vecs[v].n; c++) begin
        rst         = vecs[v].rst;
        btn_pulse   = vecs[v].pulse;
        evt_ready   = vecs[v].rdy;
        clr_overrun = vecs[v].clr;
        chk("evt_valid", v, 8'(evt_valid), 8'(vecs[v].exp_valid));
        chk("busy", v, 8'(busy), 8'(vecs[v].exp_busy));
        chk("overrun", v, 8'(overrun), 8'(vecs[v].exp_ovr));
        if (vecs[v].chk_id) begin
          chk("evt_id", v, 8'(evt_id), 8'(vecs[v].exp_id));
        end
        @(posedge clk);
        #1;
      end
    end

    // Round robin with every button kept pending: each granted button is
    // pressed again in its accept cycle. Expected order 0,1,2,3,0,1,2,3 with
    // exactly 17 non-valid cycles between consecutive grants.
    rst         = 1'b0;
    evt_ready   = 1'b1;
    clr_overrun = 1'b0;
    btn_pulse   = 4'b1111;
    @(posedge clk);
    #1;
    btn_pulse = 4'b0000;
    for (g = 0; g < 8; g++) begin
      cnt = 0;
      while (evt_valid !== 1'b1 && cnt < 40) begin
        @(posedge clk);
        #1;
        cnt++;
      end
      if (cnt >= 40) begin
        checks++;
        failures++;
        $display("FAIL rr_wait grant=%0d actual=timeout required=evt_valid", g);
        break;
      end
      chk("rr_id", 1000 + g, 8'(evt_id), 8'(g % 4));
      chk("rr_gap", 1000 + g, 8'(cnt), (g == 0) ? 8'd1 : 8'd17);
      btn_pulse = 4'b0001 << (g % 4);
      @(posedge clk);
      #1;
      btn_pulse = 4'b0000;
    end
    chk("rr_overrun", 2000, 8'(overrun), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
